// File: rtl/comparador_serial_derizq_pkg.sv
// Shared definitions for the serial right-to-left comparator.
// FSM state encodings and the reset value of the running result.
package comparador_serial_derizq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Empty prefix compares equal, and equal means A <= B.
  localparam logic Z_RST = 1'b1;

endpackage

// File: rtl/comparador_serial_derizq_celda.sv
// One cell of the right-to-left comparator network.
// Ports: a, b (operand bits), zin (result so far), zout (updated result).
module celda_comp_derizq (
  input  logic a,
  input  logic b,
  input  logic zin,
  output logic zout
);

  // A differing bit overrides everything below it: a=1,b=0 -> 0; a=0,b=1 -> 1.
  assign zout = (a ^ b) ? b : zin;

endmodule

// File: rtl/comparador_serial_derizq.sv
// Bit-serial comparator: Zout=1 when A <= B, one cell per clock, LSB first.
// Ports: clk, reset (async high), start, A, B in; busy, done (pulse), Zout out.
module comparador_serial_derizq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic         Zout
);

  import comparador_serial_derizq_pkg::*;

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  state_t        state_n;
  logic [N-1:0]  sa;
  logic [N-1:0]  sb;
  logic [CW-1:0] cnt;
  logic          z;
  logic          zc;

  celda_comp_derizq u_cell (
    .a    (sa[0]),
    .b    (sb[0]),
    .zin  (z),
    .zout (zc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:  if (start) state_n = ST_SHIFT;
      ST_SHIFT: if (cnt == LAST) state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // The last cell lands in z on the SHIFT->DONE edge, so the
  // result is published one edge later, as the FSM returns to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sa   <= '0;
      sb   <= '0;
      cnt  <= '0;
      z    <= Z_RST;
      done <= 1'b0;
      Zout <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            sa  <= A;
            sb  <= B;
            cnt <= '0;
            z   <= Z_RST;
          end
        end
        ST_SHIFT: begin
          z   <= zc;
          sa  <= {1'b0, sa[N-1:1]};
          sb  <= {1'b0, sb[N-1:1]};
          cnt <= cnt + CW'(1);
        end
        ST_DONE: begin
          done <= 1'b1;
          Zout <= z;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
